bcd_serial_adder: RTL and testbench

//   Digit-serial N-digit packed-BCD adder built around one bcd_fadd_1digit instance.

---
 rtl/bcd_serial_adder_if.sv | 29 ++
 rtl/bcd_serial_adder.sv | 171 +++++++++++++++++
 tb/tb_bcd_serial_adder.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/bcd_serial_adder_if.sv
// Handshake bundle for bcd_serial_adder.
//   Input side : in_valid/in_ready transfer operands a, b and carry-in cin.
//   Output side: out_valid/out_ready transfer sum, cout and err.
// The master modport drives operands and consumes results. The slave modport
// is the adder itself.
interface bcd_serial_adder_if #(
  parameter int NDIGITS = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [4*NDIGITS-1:0]   a;
  logic [4*NDIGITS-1:0]   b;
  logic                   cin;
  logic                   out_valid;
  logic                   out_ready;
  logic [4*NDIGITS-1:0]   sum;
  logic                   cout;
  logic                   err;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, err
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, err
  );
endinterface

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder.
// The operands are latched on acceptance. One digit pair per cycle (LSD first)
// is then fed through a single 1-digit BCD adder, and the inter-digit carry is
// held in a register. Result timing is fixed: out_valid rises NDIGITS edges
// after the acceptance edge.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous reset, active-high
//   bus  - bcd_serial_adder_if.slave carrying the operand and result handshakes
//          (in_valid/in_ready, a, b, cin, out_valid/out_ready, sum, cout, err)

// Combinational single-digit BCD adder: binary add, then +6 correction when
// the binary result exceeds 9.
//   a, b : BCD digits, cin : carry-in, s : BCD sum digit, cout : decimal carry
module bcd_fadd_1digit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] bin_sum;
  logic [4:0] adj_sum;

  always_comb begin
    bin_sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    cout    = (bin_sum > 5'd9);
    adj_sum = cout ? (bin_sum + 5'd6) : bin_sum;
    s       = adj_sum[3:0];
  end
endmodule

module bcd_serial_adder #(
  parameter int NDIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  bcd_serial_adder_if.slave   bus
);
  localparam int W     = 4 * NDIGITS;
  localparam int IDX_W = $clog2(NDIGITS + 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t             state_q,     state_d;
  logic [IDX_W-1:0]   idx_q,       idx_d;
  logic               carry_q,     carry_d;
  logic [W-1:0]       a_q,         a_d;
  logic [W-1:0]       b_q,         b_d;
  logic [W-1:0]       sum_q,       sum_d;
  logic               cout_q,      cout_d;
  logic               err_q,       err_d;
  logic               in_ready_q,  in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [3:0]         dig_a, dig_b, dig_s;
  logic               dig_cout;
  logic               bad_digit;

  bcd_fadd_1digit u_fadd (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (carry_q),
    .s    (dig_s),
    .cout (dig_cout)
  );

  // Flag any nibble of either incoming operand that is not a decimal digit.
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (bus.a[4*i +: 4] > 4'd9 || bus.b[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // Select the current digit pair. The loop form keeps the index in range
  // when idx has already moved past the last digit.
  always_comb begin
    dig_a = 4'd0;
    dig_b = 4'd0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        dig_a = a_q[4*i +: 4];
        dig_b = b_q[4*i +: 4];
      end
    end
  end

  // NOTE: every signal gets a default at the top of the block, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          err_d   = bad_digit;
          state_d = ADD;
        end
      end
      ADD: begin
        // An erroneous operation still takes the full NDIGITS cycles, but its
        // sum stays at zero.
        for (int i = 0; i < NDIGITS; i++) begin
          if (idx_q == IDX_W'(i) && !err_q) sum_d[4*i +: 4] = dig_s;
        end
        carry_d = dig_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_W'(NDIGITS - 1)) begin
          cout_d  = dig_cout & ~err_q;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Handshake outputs are registered from the next state.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder (NDIGITS=4).
// Directed cases plus randomized operations, checked against a decimal
// reference model. Inputs are driven and outputs sampled on the falling edge.
module tb_bcd_serial_adder;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bcd_serial_adder_if #(.NDIGITS(N)) bus_if ();

  bcd_serial_adder #(.NDIGITS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Decimal reference: convert the operands to integers, add, and split the
  // result back into digits. Any non-decimal nibble forces a zero result.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       output logic [W-1:0] s, output logic co, output logic e);
    longint va = 0, vb = 0, vs, p = 1, lim = 1;
    logic [3:0] na, nb;
    e = 1'b0;
    for (int i = 0; i < N; i++) begin
      na = a[4*i +: 4];
      nb = b[4*i +: 4];
      if (na > 9 || nb > 9) e = 1'b1;
      va += longint'(na) * p;
      vb += longint'(nb) * p;
      p  *= 10;
    end
    lim = p;
    vs  = va + vb + longint'(ci);
    s   = '0;
    co  = 1'b0;
    if (!e) begin
      co = (vs >= lim);
      for (int i = 0; i < N; i++) begin
        s[4*i +: 4] = 4'(vs % 10);
        vs /= 10;
      end
    end
  endtask

  // Present operands and hold them until one acceptance edge has passed.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    int waited = 0;
    bus_if.in_valid = 1'b1;
    bus_if.a        = a;
    bus_if.b        = b;
    bus_if.cin      = ci;
    while (!bus_if.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready_wait", bus_if.in_ready, 1'b1);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    bus_if.a        = W'($urandom);
    bus_if.b        = W'($urandom);
    bus_if.cin      = 1'($urandom);
  endtask

  // Called at the first falling edge after acceptance. Checks the latency and
  // the result, optionally applies backpressure, then drains the result.
  task automatic finish_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic ci, input int bp);
    logic [W-1:0] es;
    logic eco, ee;
    int   cyc = 0;
    model(a, b, ci, es, eco, ee);
    while (!bus_if.out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(N));
    check({tag, "_sum"},  bus_if.sum,  es);
    check({tag, "_cout"}, bus_if.cout, eco);
    check({tag, "_err"},  bus_if.err,  ee);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check({tag, "_bp_valid"}, bus_if.out_valid, 1'b1);
      check({tag, "_bp_sum"},   bus_if.sum,       es);
      check({tag, "_bp_ready"}, bus_if.in_ready,  1'b0);
    end
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    bus_if.out_ready = 1'b0;
    check({tag, "_drain_valid"}, bus_if.out_valid, 1'b0);
    check({tag, "_drain_ready"}, bus_if.in_ready,  1'b1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input int bp);
    start_op(a, b, ci);
    check({tag, "_early_valid"}, bus_if.out_valid, 1'b0);
    finish_op(tag, a, b, ci, bp);
  endtask

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v;
    for (int i = 0; i < N; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    bus_if.a         = '0;
    bus_if.b         = '0;
    bus_if.cin       = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready",  bus_if.in_ready,  1'b0);
    check("rst_out_valid", bus_if.out_valid, 1'b0);
    check("rst_sum",       bus_if.sum,       '0);
    check("rst_cout",      bus_if.cout,      1'b0);
    check("rst_err",       bus_if.err,       1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", bus_if.in_ready, 1'b1);

    // Directed arithmetic cases
    run_op("d1234_5678", 16'h1234, 16'h5678, 1'b0, 0);
    run_op("d9999_0001", 16'h9999, 16'h0001, 1'b0, 0);
    run_op("d9999_9999", 16'h9999, 16'h9999, 1'b1, 0);
    run_op("d0000_0000", 16'h0000, 16'h0000, 1'b0, 0);
    run_op("derr",       16'h12A4, 16'h0001, 1'b0, 0);

    // Backpressure while a second operand is offered
    start_op(16'h4321, 16'h1111, 1'b1);
    finish_op("bp_pre", 16'h4321, 16'h1111, 1'b1, 0);
    start_op(16'h0456, 16'h0789, 1'b0);
    begin
      int cyc = 0;
      while (!bus_if.out_valid && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      check("bp_latency", 64'(cyc), 64'(N));
      check("bp_sum", bus_if.sum, 16'h1245);
      bus_if.in_valid = 1'b1;
      bus_if.a        = 16'h0321;
      bus_if.b        = 16'h0123;
      bus_if.cin      = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check("bp_hold_valid", bus_if.out_valid, 1'b1);
        check("bp_hold_sum",   bus_if.sum,       16'h1245);
        check("bp_hold_cout",  bus_if.cout,      1'b0);
        check("bp_hold_ready", bus_if.in_ready,  1'b0);
      end
      bus_if.out_ready = 1'b1;
      @(negedge clk);
      bus_if.out_ready = 1'b0;
      check("bp_release_valid", bus_if.out_valid, 1'b0);
      check("bp_release_ready", bus_if.in_ready,  1'b1);
      @(negedge clk);
      bus_if.in_valid = 1'b0;
      check("bp_taken_ready", bus_if.in_ready, 1'b0);
      finish_op("bp_offered", 16'h0321, 16'h0123, 1'b0, 0);
    end

    // Reset in the middle of an operation
    start_op(16'h1234, 16'h1111, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", bus_if.out_valid, 1'b0);
    check("mid_rst_ready", bus_if.in_ready,  1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_mid_rst_valid", bus_if.out_valid, 1'b0);
      check("post_mid_rst_ready", bus_if.in_ready,  1'b1);
    end
    run_op("d0005_0005", 16'h0005, 16'h0005, 1'b0, 0);
    check("d0005_sum_const", bus_if.sum, 16'h0010);

    // Randomized operations, occasionally with a non-decimal nibble
    for (int n = 0; n < 40; n++) begin
      ra = rand_bcd();
      rb = rand_bcd();
      rc = 1'($urandom);
      if ($urandom_range(0, 7) == 0) ra[4*$urandom_range(0, N-1) +: 4] = 4'($urandom_range(10, 15));
      if ($urandom_range(0, 7) == 0) rb[4*$urandom_range(0, N-1) +: 4] = 4'($urandom_range(10, 15));
      run_op("rand", ra, rb, rc, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
